// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel array controller.
// Gray/binary helpers work on a fixed 32-bit container; callers cast to their width.
package pixel_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_N_PIXELS = 4;
    localparam int FN_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ_ON,
        READ_SAMPLE,
        HANDSHAKE
    } state_t;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits leave the lower bits unaffected, so narrower codes convert correctly.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_ramp_counter.sv
// Conversion ramp counter: DATA_W+1 bits, the carry into the top bit marks the last code.
// With GRAY_CODE_EN defined the code output is Gray-encoded, otherwise plain binary.
module pixel_ramp_counter
    import pixel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    output logic [DATA_W-1:0] code,
    output logic              terminal
);

    logic [DATA_W:0] count_reg;
    logic [DATA_W:0] count_next;

    assign count_next = count_reg + (DATA_W + 1)'(1);
    assign terminal   = count_next[DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_next;
        end
    end

`ifdef GRAY_CODE_EN
    assign code = DATA_W'(bin2gray(FN_W'(count_reg[DATA_W-1:0])));
`else
    assign code = count_reg[DATA_W-1:0];
`endif

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a shared-bus pixel array: erase, expose, ramp conversion, readout stream.
// GRAY_CODE_EN selects a Gray ramp on the bus with Gray->binary conversion of captured codes.
module pixel_array_ctrl
    import pixel_pkg::*;
#(
    parameter int N_PIXELS   = DEF_N_PIXELS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ERASE_CYC  = 5,
    parameter int EXPOSE_CYC = 255,
    localparam int IDX_W     = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic [N_PIXELS-1:0] read,
    output logic                data_drive,
    output logic [DATA_W-1:0]   data_out,
    input  logic [DATA_W-1:0]   data_in,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [IDX_W-1:0]    pix_idx,
    output logic [DATA_W-1:0]   pix_data,
    output logic                busy,
    output logic                frame_done
);

    localparam int MAX_CYC  = (ERASE_CYC > EXPOSE_CYC) ? ERASE_CYC : EXPOSE_CYC;
    localparam int TIMER_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIXELS - 1);

    state_t              state_reg, state_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [IDX_W-1:0]    pix_idx_reg;
    logic [DATA_W-1:0]   pix_data_reg;
    logic                frame_done_reg, frame_done_next;
    logic                capture;
    logic [DATA_W-1:0]   ramp_code;
    logic                ramp_terminal;
    logic [DATA_W-1:0]   captured;

    pixel_ramp_counter #(
        .DATA_W(DATA_W)
    ) u_ramp (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_reg != CONVERT),
        .enable  (state_reg == CONVERT),
        .code    (ramp_code),
        .terminal(ramp_terminal)
    );

`ifdef GRAY_CODE_EN
    assign captured = DATA_W'(gray2bin(FN_W'(data_in)));
`else
    assign captured = data_in;
`endif

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        idx_next        = idx_reg;
        frame_done_next = 1'b0;
        capture         = 1'b0;
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            timer_next = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = ERASE;
                        timer_next = '0;
                        idx_next   = '0;
                    end
                end
                ERASE: begin
                    if (timer_reg == TIMER_W'(ERASE_CYC - 1)) begin
                        state_next = EXPOSE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end
                EXPOSE: begin
                    if (timer_reg == TIMER_W'(EXPOSE_CYC - 1)) begin
                        state_next = CONVERT;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end
                CONVERT: begin
                    if (ramp_terminal) begin
                        state_next = READ_ON;
                    end
                end
                // One idle read cycle lets the bus turn around before sampling.
                READ_ON: state_next = READ_SAMPLE;
                READ_SAMPLE: begin
                    capture    = 1'b1;
                    state_next = HANDSHAKE;
                end
                HANDSHAKE: begin
                    if (pix_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_next      = IDLE;
                            frame_done_next = 1'b1;
                        end else begin
                            idx_next   = idx_reg + IDX_W'(1);
                            state_next = READ_ON;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            idx_reg        <= '0;
            pix_idx_reg    <= '0;
            pix_data_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            idx_reg        <= idx_next;
            frame_done_reg <= frame_done_next;
            if (capture) begin
                pix_idx_reg  <= idx_reg;
                pix_data_reg <= captured;
            end
        end
    end

    assign erase      = (state_reg == ERASE);
    assign expose     = (state_reg == EXPOSE);
    assign convert    = (state_reg == CONVERT);
    assign data_drive = (state_reg == CONVERT);
    assign data_out   = data_drive ? ramp_code : '0;
    assign read       = (state_reg == READ_ON || state_reg == READ_SAMPLE)
                        ? (N_PIXELS'(1) << idx_reg) : '0;
    assign pix_valid  = (state_reg == HANDSHAKE);
    assign pix_idx    = pix_idx_reg;
    assign pix_data   = pix_data_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Randomized bench for pixel_array_ctrl with a timeline-based frame model and bus-side pixel models.
// Define GRAY_CODE_EN to exercise the Gray ramp build (DATA_W=4, N_PIXELS=1).
module tb_pixel_array_ctrl;

`ifdef GRAY_CODE_EN
    localparam int NP = 1;
    localparam int DW = 4;
`else
    localparam int NP = 4;
    localparam int DW = 8;
`endif
    localparam int E    = 5;
    localparam int X    = 255;
    localparam int CONV = 1 << DW;
    localparam int RS   = E + X + CONV;
    localparam int IW   = (NP > 1) ? $clog2(NP) : 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          erase, expose, convert, data_drive, pix_valid, busy, frame_done;
    logic [NP-1:0] read;
    logic [DW-1:0] data_out, data_in, pix_data, garbage;
    logic          pix_ready;
    logic [IW-1:0] pix_idx;

    pixel_array_ctrl #(
        .N_PIXELS(NP), .DATA_W(DW), .ERASE_CYC(E), .EXPOSE_CYC(X)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .data_drive(data_drive), .data_out(data_out), .data_in(data_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_idx(pix_idx),
        .pix_data(pix_data), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // frame model: position on the frame timeline plus readout progress
    bit m_in_frame = 0;
    int m_t = 0;
    int m_acc = 0;
    bit m_done_exp = 0;
    bit m_read_seen = 0;
    int trip [NP];
    int latched [NP];
    bit tripped [NP];
    int s_erase, s_expose, s_conv, s_done, done_t, last_code;
    int first_codes [5];
    int accept_t [NP];
    int log_idx [$];
    int log_data [$];
    int lit_trip [NP];
    int lit_first [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    function automatic int exp_code(input int n);
`ifdef GRAY_CODE_EN
        return (n ^ (n >> 1)) & (CONV - 1);
`else
        return n & (CONV - 1);
`endif
    endfunction

    function automatic int bus_to_bin(input int v);
        int b;
        b = v;
`ifdef GRAY_CODE_EN
        for (int s = 1; s < DW; s++) b = b ^ (v >> s);
`endif
        return b;
    endfunction

    always_comb begin
        data_in = garbage;
        if (data_drive) begin
            data_in = data_out;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (read[i]) data_in = DW'(latched[i]);
            end
        end
    end

    // pixel comparators: latch the bus value when the ramp reaches the pixel's level
    always @(negedge clk) begin
        if (start && !busy) begin
            for (int i = 0; i < NP; i++) begin
                tripped[i] = 0;
                latched[i] = 0;
            end
        end else if (convert) begin
            for (int i = 0; i < NP; i++) begin
                if (!tripped[i] && bus_to_bin(int'(data_out)) == trip[i]) begin
                    latched[i] = int'(data_out);
                    tripped[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit in_e, in_x, in_c, acc_now, nd;
        logic [DW-1:0] ec;
        if (!reset_n) begin
            chk("reset_outputs", 64'({busy, erase, expose, convert, data_drive, data_out, read,
                                      pix_valid, pix_idx, pix_data, frame_done}), 64'(0));
            m_in_frame = 0;
            m_done_exp = 0;
        end else begin
            chk("drive_read_excl", 64'(data_drive & (|read)), 64'(0));
            chk("read_onehot0", 64'($onehot0(read)), 64'(1));
            if (!m_in_frame || m_t < RS) begin
                in_e = m_in_frame && m_t < E;
                in_x = m_in_frame && m_t >= E && m_t < E + X;
                in_c = m_in_frame && m_t >= E + X && m_t < RS;
                ec   = in_c ? DW'(exp_code(m_t - E - X)) : '0;
                chk("ctrl", 64'({busy, erase, expose, convert, data_drive, data_out, read, pix_valid, frame_done}),
                            64'({m_in_frame, in_e, in_x, in_c, in_c, ec, NP'(0), 1'b0, m_done_exp}));
                if (erase) s_erase++;
                if (expose) s_expose++;
                if (convert) s_conv++;
                if (frame_done) s_done++;
                if (in_c && m_t - E - X < 5) first_codes[m_t - E - X] = int'(data_out);
                if (in_c && m_t == RS - 1) last_code = int'(data_out);
            end else begin
                chk("readout_ctrl", 64'({busy, erase, expose, convert, data_drive, data_out, frame_done}),
                                    64'({1'b1, 4'b0, DW'(0), 1'b0}));
                if (|read) begin
                    chk("read_order", 64'(read), 64'(NP'(1) << m_acc));
                    if (read == (NP'(1) << m_acc)) m_read_seen = 1;
                end
                if (pix_valid) begin
                    chk("valid_after_read", 64'(m_read_seen), 64'(1));
                    chk("valid_read_low", 64'(read), 64'(0));
                    chk("pix_idx", 64'(pix_idx), 64'(m_acc));
                    chk("pix_data", 64'(pix_data), 64'(trip[m_acc]));
                end
            end
            acc_now = m_in_frame && m_t >= RS && pix_valid && pix_ready && !abort;
            nd = 0;
            if (m_in_frame && abort) begin
                m_in_frame = 0;
            end else if (!m_in_frame) begin
                if (start) begin
                    m_in_frame = 1; m_t = 0; m_acc = 0; m_read_seen = 0;
                    s_erase = 0; s_expose = 0; s_conv = 0; s_done = 0; done_t = -1;
                    log_idx.delete(); log_data.delete();
                end
            end else begin
                if (acc_now) begin
                    $display("pixel idx=%0d data=%0d t=%0d", pix_idx, pix_data, m_t);
                    log_idx.push_back(int'(pix_idx));
                    log_data.push_back(int'(pix_data));
                    accept_t[m_acc] = m_t;
                    if (m_acc == NP - 1) begin
                        m_in_frame = 0; nd = 1; done_t = m_t + 1;
                    end else begin
                        m_acc++; m_read_seen = 0;
                    end
                end
                m_t++;
            end
            m_done_exp = nd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        garbage = DW'($urandom);
    endtask

    task automatic rand_trips();
        for (int i = 0; i < NP; i++) trip[i] = int'($urandom_range(0, CONV - 1));
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rmode);
        int n;
        n = 0;
        while (m_in_frame && n < budget) begin
            pix_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        chk("frame_timeout", 64'(n < budget), 64'(1));
        pix_ready = 1'b1;
        step();
    endtask

    task automatic wait_t(input int target, input string name);
        int n;
        n = 0;
        while (!(m_in_frame && m_t == target) && n < 2000) begin
            step();
            n++;
        end
        chk(name, 64'(n < 2000), 64'(1));
    endtask

    initial begin
        int n, stall_pix, abort_code, rp;
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish, required finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stall_pix, abort_code, rp;
`ifdef GRAY_CODE_EN
        lit_trip  = '{8};
        lit_first = '{0, 1, 3, 2, 6};
`else
        lit_trip  = '{10, 20, 30, 255};
        lit_first = '{0, 1, 2, 3, 4};
`endif
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1; garbage = '0;
        rand_trips();
        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'(0));
        #2 reset_n = 1'b1;
        repeat (3) step();

        // frame 1: fixed trip levels, consumer always ready
        for (int i = 0; i < NP; i++) trip[i] = lit_trip[i];
        start_frame();
        wait_idle(2000, 0);
        chk("t1_erase_len", 64'(s_erase), 64'(5));
        chk("t1_expose_len", 64'(s_expose), 64'(255));
        chk("t1_conv_len", 64'(s_conv), 64'(CONV));
        chk("t1_done_pulses", 64'(s_done), 64'(1));
        chk("t1_done_time", 64'(done_t), 64'(E + X + CONV + 3 * NP));
        chk("t1_last_code", 64'(last_code), 64'(exp_code(CONV - 1)));
        for (int k = 0; k < 5; k++) chk("t1_first_codes", 64'(first_codes[k]), 64'(lit_first[k]));
        chk("t1_stream_len", 64'(log_idx.size()), 64'(NP));
        for (int k = 0; k < NP && k < log_idx.size(); k++) begin
            chk("t1_stream_idx", 64'(log_idx[k]), 64'(k));
            chk("t1_stream_data", 64'(log_data[k]), 64'(lit_trip[k]));
            chk("t1_accept_time", 64'(accept_t[k]), 64'(RS + 2 + 3 * k));
        end

        // frame 2: stall on one pixel, start re-pulses while busy
        rand_trips();
        stall_pix = (NP > 2) ? 2 : 0;
        start_frame();
        n = 0;
        while (!(m_in_frame && m_acc == stall_pix && pix_valid) && n < 2000) begin
            start = (m_t == E + 10);
            step();
            n++;
        end
        start = 1'b0;
        chk("t2_reach_stall", 64'(n < 2000), 64'(1));
        for (int i = 0; i < 20; i++) begin
            pix_ready = 1'b0;
            start = (i == 5);
            step();
            chk("t2_stall_valid", 64'(pix_valid), 64'(1));
            chk("t2_stall_read", 64'(read), 64'(0));
            chk("t2_stall_idx", 64'(pix_idx), 64'(stall_pix));
        end
        start = 1'b0;
        wait_idle(2000, 0);
        chk("t2_stream_len", 64'(log_idx.size()), 64'(NP));
        chk("t2_done_pulses", 64'(s_done), 64'(1));

        // frame 3: abort mid-conversion, then a clean frame
        rand_trips();
        abort_code = (CONV > 100) ? 100 : CONV / 2;
        start_frame();
        wait_t(E + X + abort_code, "t3_reach_abort");
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_outs", 64'({data_drive, convert, busy}), 64'(0));
        repeat (10) step();
        chk("t3_no_done", 64'(s_done), 64'(0));
        rand_trips();
        start_frame();
        wait_idle(3000, 1);
        chk("t3_clean_len", 64'(log_idx.size()), 64'(NP));
        chk("t3_clean_done", 64'(s_done), 64'(1));

        // frame 4: asynchronous reset while a pixel is being sampled
        rand_trips();
        rp = (NP > 1) ? 1 : 0;
        start_frame();
        wait_t(RS + 1 + 3 * rp, "t4_reach_sample");
        chk("t4_in_sample", 64'(read), 64'(NP'(1) << rp));
        #2 reset_n = 1'b0;
        #1 chk("t4_async_outs", 64'({busy, erase, expose, convert, data_drive, data_out, read,
                                      pix_valid, pix_idx, pix_data, frame_done}), 64'(0));
        step();
        step();
        #3 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_idle_after_reset", 64'(busy), 64'(0));
        end

        // random frames with random consumer backpressure
        for (int f = 0; f < 3; f++) begin
            rand_trips();
            start_frame();
            wait_idle(3000, 1);
            chk("rand_stream_len", 64'(log_idx.size()), 64'(NP));
            chk("rand_done_pulses", 64'(s_done), 64'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
